// File: rtl/pic_host_bus_master.sv
// CPU-side bus master for an 8259-style PIC. It runs the ICW/OCW1
// initialisation sequence, performs single host reads and writes, and
// answers INT with a two-pulse INTA_ acknowledge that captures the vector.
module pic_host_bus_master #(
  parameter int STROBE_W = 2,
  parameter int GAP_W    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_start,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  input  logic [7:0] ocw1,
  input  logic       req_valid,
  input  logic       req_write,
  input  logic       req_a0,
  input  logic [7:0] req_wdata,
  output logic       req_ack,
  output logic [7:0] req_rdata,
  input  logic       INT,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       WR_,
  output logic       RD_,
  output logic       A0,
  output logic       INTA_,
  output logic [7:0] vector,
  output logic       vector_valid,
  output logic       ready
);

  typedef enum logic [3:0] {
    UNINIT, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_STROBE, R_HOLD,
    READY, ACK1, ACK_GAP, ACK2, ACK_DONE
  } state_t;

  typedef enum logic [2:0] {
    STEP_ICW1, STEP_ICW2, STEP_ICW3, STEP_ICW4, STEP_OCW1
  } step_t;

  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_W - 1);
  localparam logic [3:0] GAP_LOAD    = 4'(GAP_W - 1);

  state_t     r_state, w_next;
  step_t      r_step, w_step_nxt;
  logic [3:0] r_cnt;
  logic       r_init;
  logic       r_sngl, r_ic4;
  logic [7:0] r_icw2, r_icw3, r_icw4, r_ocw1;
  logic [7:0] r_a0_unused_guard;
  logic       r_a0;
  logic [7:0] r_wdata, r_rdata, r_vector;
  logic       r_armed;
  logic       w_start, w_cnt_zero, w_last_step;
  logic [7:0] w_step_data;

  assign w_start     = init_start && (r_state == UNINIT || r_state == READY);
  assign w_cnt_zero  = (r_cnt == '0);
  assign w_last_step = (r_step == STEP_OCW1);

  // Pick the next init step, skipping ICW3 in single mode and ICW4 when IC4=0
  always_comb begin
    w_step_nxt  = r_step;
    w_step_data = r_ocw1;
    case (r_step)
      STEP_ICW1: w_step_nxt = STEP_ICW2;
      STEP_ICW2: w_step_nxt = !r_sngl ? STEP_ICW3 : (r_ic4 ? STEP_ICW4 : STEP_OCW1);
      STEP_ICW3: w_step_nxt = r_ic4 ? STEP_ICW4 : STEP_OCW1;
      STEP_ICW4: w_step_nxt = STEP_OCW1;
      default:   w_step_nxt = STEP_OCW1;
    endcase
    case (w_step_nxt)
      STEP_ICW2: w_step_data = r_icw2;
      STEP_ICW3: w_step_data = r_icw3;
      STEP_ICW4: w_step_data = r_icw4;
      default:   w_step_data = r_ocw1;
    endcase
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      UNINIT:   if (w_start) w_next = W_SETUP;
      READY: begin
        if (w_start)                w_next = W_SETUP;
        else if (INT && r_armed)    w_next = ACK1;
        else if (req_valid)         w_next = req_write ? W_SETUP : R_SETUP;
      end
      W_SETUP:  w_next = W_STROBE;
      W_STROBE: if (w_cnt_zero) w_next = W_HOLD;
      W_HOLD:   w_next = (r_init && !w_last_step) ? W_SETUP : READY;
      R_SETUP:  w_next = R_STROBE;
      R_STROBE: if (w_cnt_zero) w_next = R_HOLD;
      R_HOLD:   w_next = READY;
      ACK1:     if (w_cnt_zero) w_next = ACK_GAP;
      ACK_GAP:  if (w_cnt_zero) w_next = ACK2;
      ACK2:     if (w_cnt_zero) w_next = ACK_DONE;
      ACK_DONE: w_next = READY;
      default:  w_next = UNINIT;
    endcase
  end

  // State-decoded bus strobes and handshake pulses
  always_comb begin
    WR_          = 1'b1;
    RD_          = 1'b1;
    INTA_        = 1'b1;
    data_oe      = 1'b0;
    req_ack      = 1'b0;
    vector_valid = 1'b0;
    ready        = 1'b0;
    case (r_state)
      W_SETUP:  data_oe = 1'b1;
      W_STROBE: begin data_oe = 1'b1; WR_ = 1'b0; end
      W_HOLD:   begin data_oe = 1'b1; req_ack = !r_init; end
      R_STROBE: RD_ = 1'b0;
      R_HOLD:   req_ack = 1'b1;
      ACK1:     INTA_ = 1'b0;
      ACK2:     INTA_ = 1'b0;
      ACK_DONE: vector_valid = 1'b1;
      READY:    ready = 1'b1;
      default:  ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= UNINIT;
    else     r_state <= w_next;
  end

  // Strobe/gap down-counter, reloaded on every state change
  always_ff @(posedge clk) begin
    if (rst)                    r_cnt <= '0;
    else if (w_next != r_state) r_cnt <= (w_next == ACK_GAP) ? GAP_LOAD : STROBE_LOAD;
    else if (!w_cnt_zero)       r_cnt <= r_cnt - 4'd1;
  end

  // Config latch, init-step pointer, bus address/data and captured read/vector data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_init   <= 1'b0;
      r_step   <= STEP_ICW1;
      r_sngl   <= 1'b0;
      r_ic4    <= 1'b0;
      r_icw2   <= '0;
      r_icw3   <= '0;
      r_icw4   <= '0;
      r_ocw1   <= '0;
      r_a0     <= 1'b0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_vector <= '0;
    end else begin
      if (w_start) begin
        r_init  <= 1'b1;
        r_step  <= STEP_ICW1;
        r_sngl  <= icw1[1];
        r_ic4   <= icw1[0];
        r_icw2  <= icw2;
        r_icw3  <= icw3;
        r_icw4  <= icw4;
        r_ocw1  <= ocw1;
        r_a0    <= 1'b0;
        r_wdata <= icw1;
      end else if (r_state == READY && w_next == W_SETUP) begin
        r_a0    <= req_a0;
        r_wdata <= req_wdata;
      end else if (r_state == READY && w_next == R_SETUP) begin
        r_a0    <= req_a0;
      end else if (r_state == W_HOLD && r_init) begin
        if (w_last_step) begin
          r_init <= 1'b0;
        end else begin
          r_step  <= w_step_nxt;
          r_a0    <= 1'b1;
          r_wdata <= w_step_data;
        end
      end
      if (r_state == R_STROBE && w_cnt_zero) r_rdata  <= data_in;
      if (r_state == ACK2 && w_cnt_zero)     r_vector <= data_in;
    end
  end

  // Ack re-arm: cleared after an acknowledge, set once INT is seen low
  always_ff @(posedge clk) begin
    if (rst)                      r_armed <= 1'b0;
    else if (r_state == ACK_DONE) r_armed <= 1'b0;
    else if (!INT)                r_armed <= 1'b1;
  end

  assign r_a0_unused_guard = '0;
  assign A0        = r_a0;
  assign data_out  = r_wdata;
  assign req_rdata = r_rdata;
  assign vector    = r_vector;

endmodule

// File: doc/pic_host_bus_master.md
Name: pic_host_bus_master

Overview:
- CPU-side initiator for the 8259-style PIC control unit. Drives its WR/RD/A0/INTA_ pins from one synchronous clock.
- Runs the ICW1..ICW4 + OCW1 initialisation sequence from configuration inputs.
- Services single OCW writes and register reads for the host.
- Answers INT with the two-pulse INTA_ acknowledge and captures the interrupt vector.
- Used as the bench/system master for the PIC.

Parameters:
- STROBE_W, 2, cycles a strobe (WR_, RD_, INTA_) is held low; legal 1..15
- GAP_W, 2, cycles INTA_ is high between the first and second INTA pulse; legal 1..15

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- init_start  in  1  one-cycle pulse: begin init sequence
- icw1  in  8  ICW1 byte (bit1 SNGL, bit0 IC4 steer the sequence)
- icw2  in  8  ICW2 byte (vector base)
- icw3  in  8  ICW3 byte
- icw4  in  8  ICW4 byte
- ocw1  in  8  initial mask byte
- req_valid  in  1  host access request
- req_write  in  1  1 = write, 0 = read
- req_a0  in  1  A0 for the request
- req_wdata  in  8  write data
- req_ack  out  1  one-cycle pulse: request complete
- req_rdata  out  8  read data, valid with req_ack on reads
- INT  in  1  interrupt request from PIC
- data_in  in  8  PIC data bus sampled value
- data_out  out  8  value driven onto data bus
- data_oe  out  1  1 = master drives data bus
- WR_  out  1  write strobe, active low
- RD_  out  1  read strobe, active low
- A0  out  1  address bit
- INTA_  out  1  interrupt acknowledge, active low
- vector  out  8  captured vector
- vector_valid  out  1  one-cycle pulse: vector updated
- ready  out  1  1 = init done and FSM idle

Behaviour:
- Reset values: WR_=RD_=INTA_=1, data_oe=0, data_out=0, A0=0, vector=0, vector_valid=0, req_ack=0, req_rdata=0, ready=0. State UNINIT. Init-step pointer cleared.
- Reset mid-operation aborts any cycle. Strobes are high on the first clock after rst is asserted.
- States: UNINIT, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_STROBE, R_HOLD, READY, ACK1, ACK_GAP, ACK2, ACK_DONE.
- Write cycle:
  - W_SETUP: 1 cycle, A0/data_out driven, data_oe=1.
  - W_STROBE: STROBE_W cycles, WR_=0.
  - W_HOLD: 1 cycle, WR_=1, data still driven.
  - data_oe drops after W_HOLD. Total STROBE_W+2 cycles.
- Read cycle:
  - R_SETUP: 1 cycle, data_oe=0.
  - R_STROBE: STROBE_W cycles, RD_=0. data_in is sampled into req_rdata on the last low cycle.
  - R_HOLD: 1 cycle, req_ack=1.
- Init sequence, latched at init_start:
  - ICW1 with A0=0, then ICW2 with A0=1.
  - ICW3 with A0=1 only if icw1[1]=0.
  - ICW4 with A0=1 only if icw1[0]=1.
  - OCW1 with A0=1.
  - Back-to-back writes, no idle cycles between them. Then READY with ready=1.
- Config inputs are registered at init_start. Later changes do not affect a running sequence.
- init_start in any state other than UNINIT/READY is ignored. In READY it restarts init: ready=0.
- In READY:
  - If INT=1 and armed, enter ACK1. Interrupt has priority over a simultaneous req_valid.
  - Else if req_valid=1, run a write or read cycle. req_ack=1 in the hold cycle, then return to READY.
  - req_valid is held by the host until req_ack. It is ignored outside READY.
- Acknowledge sequence:
  - ACK1: INTA_=0 for STROBE_W cycles.
  - ACK_GAP: INTA_=1 for GAP_W cycles.
  - ACK2: INTA_=0 for STROBE_W cycles. data_in is captured into vector on the last low cycle.
  - ACK_DONE: 1 cycle, INTA_=1, vector_valid=1. Then READY.
- data_oe=0 throughout the ack sequence.
- Re-arm: after ACK_DONE the armed flag clears. It sets again once INT has been sampled 0 for at least one cycle. This prevents a double ack on a stale INT.
- Strobe counters are 4 bits. They count down from STROBE_W-1 (or GAP_W-1) to 0, then the state transitions.
- WR_, RD_, INTA_ are never low simultaneously.

Test Plan:
- rst held 3 cycles mid-W_STROBE -> WR_=1, data_oe=0, ready=0 on the next edge; state UNINIT.
- Init with icw1=0x13 (SNGL=1, IC4=1), icw2=0x20, icw4=0x01, ocw1=0xF0 -> four writes, in order A0/data = 0/0x13, 1/0x20, 1/0x01, 1/0xF0. Each write has WR_ low exactly 2 cycles. ready=1 after 16 cycles.
- Init with icw1=0x10 (cascade, no ICW4), icw3=0x04 -> writes 0x10, icw2, 0x04, ocw1. No ICW4 write occurs.
- READY, INT rises, PIC drives 0x25 during INTA2 -> INTA_ pattern is low 2, high 2, low 2. vector=0x25, vector_valid pulses once. INT kept high -> no second ack until INT has been seen low.
- INT and req_valid (write A0=0, 0x20) in the same READY cycle -> ack sequence first, then the write. req_ack pulses after the WR_ strobe.
- Read request A0=1 with data_in=0xF0 -> RD_ low 2 cycles, req_rdata=0xF0 with a req_ack pulse. data_oe stays 0.
